// File: rtl/sar_multi.sv
// Multi-channel successive-approximation ADC sequencer.
// A toggle on sar_soc starts a pass over the masked channels (lowest first).
// Each channel is sampled and converted 2^sar_avg times; the truncated mean
// is published on sar_code/sar_chan with a toggle on sar_eoc. Comparator
// handshakes use ms_sar_clock / ms_sar_rdy; a missing ready aborts the pass.
module sar_multi #(
  parameter int NBIT      = 10,
  parameter int NCHAN     = 4,
  parameter int TSAMPLE   = 4,
  parameter int STEP_SIZE = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                     f100m_clk,
  input  logic                     rstb,
  input  logic                     atpg,
  input  logic                     sar_soc,
  input  logic [NCHAN-1:0]         sar_chan_mask,
  input  logic [1:0]               sar_avg,
  output logic                     sar_busy,
  output logic                     sar_eoc,
  output logic                     sar_err,
  output logic                     sar_warn,
  output logic [NBIT-1:0]          sar_code,
  output logic [$clog2(NCHAN)-1:0] sar_chan,
  input  logic                     ms_sar_dh,
  input  logic                     ms_sar_dl,
  input  logic                     ms_sar_rdy,
  output logic                     ms_sar_clock,
  output logic                     ms_sar_sample,
  output logic [NCHAN-1:0]         ms_sar_sel,
  output logic [NBIT-1:0]          ms_sar_sw,
  output logic [NBIT-1:0]          ms_sar_swb
);

  localparam int CW   = $clog2(NCHAN);
  localparam int BW   = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam int AW   = NBIT + 3;
  localparam int TMAX = (TSAMPLE > TIMEOUT) ? TSAMPLE : TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SAMPLE, ST_CONV, ST_ACC, ST_DONE
  } st_t;

  st_t              state, state_nxt;
  logic             soc_q, armed;
  logic [NCHAN-1:0] mask_q;
  logic [1:0]       avg_q;
  logic [CW-1:0]    chan_q, nxt_chan;
  logic             nxt_vld;
  logic [TW-1:0]    cnt;
  logic [BW-1:0]    bit_idx;
  logic [NBIT-1:0]  res_q;
  logic [AW-1:0]    acc;
  logic [3:0]       conv_cnt;

  logic soc_acc, decide, tmo, samp_end, conv_last;

  // Lowest set bit of a mask; zero when the mask is empty.
  function automatic logic [CW-1:0] low_bit(input logic [NCHAN-1:0] m);
    low_bit = '0;
    for (int i = NCHAN - 1; i >= 0; i--)
      if (m[i]) low_bit = CW'(i);
  endfunction

  // soc is only meaningful once the first post-reset value has been sampled
  assign soc_acc   = armed && (sar_soc != soc_q) && (state == ST_IDLE);
  assign samp_end  = (cnt == TW'(TSAMPLE - 1));
  assign decide    = (state == ST_CONV) && (cnt >= TW'(STEP_SIZE - 1)) && ms_sar_rdy;
  assign tmo       = (state == ST_CONV) && !decide && (cnt == TW'(TIMEOUT - 1));
  assign conv_last = ((conv_cnt + 4'd1) == (4'd1 << avg_q));

  // Next channel in the pass: lowest captured mask bit above the current one.
  always_comb begin
    nxt_chan = '0;
    nxt_vld  = 1'b0;
    for (int i = NCHAN - 1; i >= 0; i--)
      if (mask_q[i] && (CW'(i) > chan_q)) begin
        nxt_chan = CW'(i);
        nxt_vld  = 1'b1;
      end
  end

  // FSM state register.
  always_ff @(posedge f100m_clk or negedge rstb)
    if (!rstb) state <= ST_IDLE;
    else       state <= state_nxt;

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (soc_acc && |sar_chan_mask) state_nxt = ST_SAMPLE;
      ST_SAMPLE: if (samp_end) state_nxt = ST_CONV;
      ST_CONV: begin
        if (tmo)                            state_nxt = ST_IDLE;
        else if (decide && (bit_idx == '0)) state_nxt = ST_ACC;
      end
      ST_ACC:    state_nxt = conv_last ? ST_DONE : ST_SAMPLE;
      ST_DONE:   state_nxt = nxt_vld ? ST_SAMPLE : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: analogue front-end controls, gated off in test mode.
  always_comb begin
    sar_busy      = (state != ST_IDLE);
    ms_sar_sample = 1'b0;
    ms_sar_sel    = '0;
    ms_sar_clock  = 1'b0;
    ms_sar_sw     = '0;
    ms_sar_swb    = '0;
    case (state)
      ST_SAMPLE: begin
        ms_sar_sample      = 1'b1;
        ms_sar_sel[chan_q] = 1'b1;
      end
      ST_CONV: begin
        ms_sar_clock = (cnt == '0);
        ms_sar_sw    = res_q | (NBIT'(1) << bit_idx);
        ms_sar_swb   = ~ms_sar_sw;
      end
      default: ;
    endcase
    if (atpg) begin
      ms_sar_sample = 1'b0;
      ms_sar_sel    = '0;
      ms_sar_sw     = '0;
      ms_sar_swb    = '0;
    end
  end

  // soc edge tracking; toggles while busy are absorbed into the copy.
  always_ff @(posedge f100m_clk or negedge rstb)
    if (!rstb) begin
      soc_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      soc_q <= sar_soc;
      armed <= 1'b1;
    end

  // Sequencing datapath: timers, bit search, accumulation and result outputs.
  always_ff @(posedge f100m_clk or negedge rstb)
    if (!rstb) begin
      mask_q   <= '0;
      avg_q    <= '0;
      chan_q   <= '0;
      cnt      <= '0;
      bit_idx  <= '0;
      res_q    <= '0;
      acc      <= '0;
      conv_cnt <= '0;
      sar_eoc  <= 1'b0;
      sar_err  <= 1'b0;
      sar_warn <= 1'b0;
      sar_code <= '0;
      sar_chan <= '0;
    end else begin
      if (soc_acc) begin
        mask_q   <= sar_chan_mask;
        avg_q    <= sar_avg;
        chan_q   <= low_bit(sar_chan_mask);
        acc      <= '0;
        conv_cnt <= '0;
        if (~|sar_chan_mask) sar_err <= ~sar_err;
      end
      case (state)
        ST_SAMPLE: begin
          cnt     <= samp_end ? '0 : cnt + 1'b1;
          bit_idx <= BW'(NBIT - 1);
          res_q   <= '0;
        end
        ST_CONV: begin
          if (decide) begin
            cnt            <= '0;
            res_q[bit_idx] <= ms_sar_dh;
            if (bit_idx != '0) bit_idx <= bit_idx - 1'b1;
            // both comparator outputs high: keep the bit but flag it
            if (ms_sar_dh && ms_sar_dl) sar_warn <= ~sar_warn;
          end else if (tmo) begin
            cnt      <= '0;
            sar_err  <= ~sar_err;
            acc      <= '0;
            conv_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ACC: begin
          acc      <= acc + AW'(res_q);
          conv_cnt <= conv_last ? 4'd0 : conv_cnt + 4'd1;
        end
        ST_DONE: begin
          sar_code <= NBIT'(acc >> avg_q);
          sar_chan <= chan_q;
          sar_eoc  <= ~sar_eoc;
          acc      <= '0;
          if (nxt_vld) chan_q <= nxt_chan;
        end
        default: cnt <= '0;
      endcase
    end

endmodule

// File: tb/tb_sar_multi.sv
// Directed bench for sar_multi with a behavioural comparator model.
module tb_sar_multi;
  localparam int NBIT  = 10;
  localparam int NCHAN = 4;

  logic             f100m_clk = 1'b0;
  logic             rstb, atpg, sar_soc;
  logic [NCHAN-1:0] sar_chan_mask;
  logic [1:0]       sar_avg;
  logic             sar_busy, sar_eoc, sar_err, sar_warn;
  logic [NBIT-1:0]  sar_code;
  logic [1:0]       sar_chan;
  logic             ms_sar_dh, ms_sar_dl, ms_sar_rdy;
  logic             ms_sar_clock, ms_sar_sample;
  logic [NCHAN-1:0] ms_sar_sel;
  logic [NBIT-1:0]  ms_sar_sw, ms_sar_swb;

  sar_multi #(.NBIT(NBIT), .NCHAN(NCHAN), .TSAMPLE(4), .STEP_SIZE(4), .TIMEOUT(15)) dut (
    .f100m_clk(f100m_clk), .rstb(rstb), .atpg(atpg), .sar_soc(sar_soc),
    .sar_chan_mask(sar_chan_mask), .sar_avg(sar_avg), .sar_busy(sar_busy),
    .sar_eoc(sar_eoc), .sar_err(sar_err), .sar_warn(sar_warn),
    .sar_code(sar_code), .sar_chan(sar_chan), .ms_sar_dh(ms_sar_dh),
    .ms_sar_dl(ms_sar_dl), .ms_sar_rdy(ms_sar_rdy), .ms_sar_clock(ms_sar_clock),
    .ms_sar_sample(ms_sar_sample), .ms_sar_sel(ms_sar_sel),
    .ms_sar_sw(ms_sar_sw), .ms_sar_swb(ms_sar_swb)
  );

  always #5 f100m_clk = ~f100m_clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge f100m_clk);
    #1;
  endtask

  // Comparator model: analogue input per conversion from codes[], indexed
  // by counting sample-phase starts since conv_base.
  logic [NBIT-1:0] codes [4];
  int              conv_n = 0, conv_base = 0, cidx;
  logic            samp_q = 1'b0;
  logic            rdy_en = 1'b1, warn_mode = 1'b0, both;
  logic [NBIT-1:0] tgt;

  always @(posedge f100m_clk) begin
    samp_q <= ms_sar_sample;
    if (ms_sar_sample && !samp_q) conv_n <= conv_n + 1;
  end

  always_comb begin
    cidx = conv_n - conv_base - 1;
    if (cidx < 0) cidx = 0;
    if (cidx > 3) cidx = 3;
    tgt        = codes[cidx];
    both       = warn_mode && (ms_sar_sw == 10'h200);
    ms_sar_dh  = (ms_sar_sw <= tgt) || both;
    ms_sar_dl  = !(ms_sar_sw <= tgt) || both;
    ms_sar_rdy = rdy_en;
  end

  // Wait for an eoc toggle; lat counts edges after the call.
  task automatic wait_eoc(input int lim, output int lat, output logic ok);
    logic prev;
    prev = sar_eoc;
    lat  = 0;
    ok   = 1'b0;
    while (!ok && lat < lim) begin
      tick();
      lat++;
      if (sar_eoc != prev) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [3:0]      mask;
    logic [1:0]      avg;
    logic [NBIT-1:0] c [4];
    int              n_eoc;
    logic [NBIT-1:0] e_code [2];
    logic [1:0]      e_chan [2];
    int              e_lat;
  } vec_t;

  vec_t vt [5];
  int   lat;
  logic ok;
  logic eoc_exp = 1'b0, err_exp = 1'b0, warn_exp = 1'b0;

  initial begin
    vt[0] = '{4'b0001, 2'd0, '{10'h2AA, 10'h0, 10'h0, 10'h0}, 1, '{10'h2AA, 10'h0}, '{2'd0, 2'd0}, 46};
    vt[1] = '{4'b1010, 2'd0, '{10'h100, 10'h3FF, 10'h0, 10'h0}, 2, '{10'h100, 10'h3FF}, '{2'd1, 2'd3}, 46};
    vt[2] = '{4'b0100, 2'd2, '{10'd100, 10'd101, 10'd102, 10'd103}, 1, '{10'd101, 10'h0}, '{2'd2, 2'd0}, 181};
    vt[3] = '{4'b0001, 2'd1, '{10'd0, 10'd1, 10'd0, 10'd0}, 1, '{10'd0, 10'h0}, '{2'd0, 2'd0}, 91};
    vt[4] = '{4'b1000, 2'd3, '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF}, 1, '{10'h3FF, 10'h0}, '{2'd3, 2'd0}, 361};

    rstb = 1'b0; atpg = 1'b0; sar_soc = 1'b0; sar_chan_mask = '0; sar_avg = '0;
    for (int i = 0; i < 4; i++) codes[i] = '0;

    // reset state
    repeat (5) tick();
    chk("rst_busy", sar_busy, 0);   chk("rst_eoc", sar_eoc, 0);
    chk("rst_err", sar_err, 0);     chk("rst_warn", sar_warn, 0);
    chk("rst_code", sar_code, 0);   chk("rst_chan", sar_chan, 0);
    chk("rst_clock", ms_sar_clock, 0); chk("rst_sample", ms_sar_sample, 0);
    chk("rst_sel", ms_sar_sel, 0);  chk("rst_sw", ms_sar_sw, 0);
    chk("rst_swb", ms_sar_swb, 0);
    rstb = 1'b1;
    repeat (4) tick();
    chk("post_rst_busy", sar_busy, 0);

    // table-driven conversion sequences
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++) codes[i] = vt[v].c[i];
      conv_base     = conv_n;
      sar_chan_mask = vt[v].mask;
      sar_avg       = vt[v].avg;
      sar_soc       = ~sar_soc;
      tick();
      chk($sformatf("v%0d_busy_start", v), sar_busy, 1);
      for (int e = 0; e < vt[v].n_eoc; e++) begin
        wait_eoc(600, lat, ok);
        chk($sformatf("v%0d_eoc%0d_seen", v, e), ok, 1);
        chk($sformatf("v%0d_eoc%0d_lat", v, e), lat, vt[v].e_lat);
        chk($sformatf("v%0d_eoc%0d_code", v, e), sar_code, vt[v].e_code[e]);
        chk($sformatf("v%0d_eoc%0d_chan", v, e), sar_chan, vt[v].e_chan[e]);
      end
      chk($sformatf("v%0d_busy_end", v), sar_busy, 0);
      tick();
    end

    // empty mask: error toggle, no conversion
    sar_chan_mask = '0;
    sar_soc = ~sar_soc;
    tick();
    err_exp = ~err_exp;
    chk("empty_err", sar_err, err_exp);
    tick();
    chk("empty_busy", sar_busy, 0);

    // ready stuck low: timeout 15 cycles after the first comparator strobe
    rdy_en = 1'b0;
    eoc_exp = sar_eoc;
    sar_chan_mask = 4'b0001;
    sar_avg = 2'd0;
    sar_soc = ~sar_soc;
    lat = 0;
    while (!ms_sar_clock && lat < 50) begin tick(); lat++; end
    chk("tmo_clock_seen", ms_sar_clock, 1);
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 40) begin
      tick();
      lat++;
      if (sar_err != err_exp) ok = 1'b1;
    end
    err_exp = ~err_exp;
    chk("tmo_err", sar_err, err_exp);
    chk("tmo_lat", lat, 15);
    chk("tmo_busy", sar_busy, 0);
    chk("tmo_no_eoc", sar_eoc, eoc_exp);
    chk("tmo_code_kept", sar_code, vt[4].e_code[0]);
    rdy_en = 1'b1;
    tick();

    // both comparator outputs high on the MSB trial
    warn_mode = 1'b1;
    codes[0] = 10'h155;
    conv_base = conv_n;
    sar_soc = ~sar_soc;
    tick();
    wait_eoc(100, lat, ok);
    warn_exp = ~warn_exp;
    chk("warn_eoc_seen", ok, 1);
    chk("warn_toggle", sar_warn, warn_exp);
    chk("warn_msb_kept", sar_code, 10'h200);
    warn_mode = 1'b0;
    tick();

    // asynchronous reset in the middle of a conversion
    codes[0] = 10'h2AA;
    conv_base = conv_n;
    sar_soc = ~sar_soc;
    repeat (12) tick();
    chk("midrst_busy_before", sar_busy, 1);
    #2 rstb = 1'b0;
    #1;
    chk("midrst_busy", sar_busy, 0);   chk("midrst_eoc", sar_eoc, 0);
    chk("midrst_err", sar_err, 0);     chk("midrst_warn", sar_warn, 0);
    chk("midrst_code", sar_code, 0);   chk("midrst_clock", ms_sar_clock, 0);
    chk("midrst_sw", ms_sar_sw, 0);    chk("midrst_swb", ms_sar_swb, 0);
    tick();
    rstb = 1'b1;
    // sar_soc stays at its pre-reset level: must not be taken as a start
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("midrst_idle%0d", i), sar_busy, 0);
    end
    sar_soc = ~sar_soc;
    tick();
    chk("rearm_busy", sar_busy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_multi.md
SAR_MULTI -- requirements
Module: sar_multi

Interface
REQ-001 Parameter NBIT, 10, converter resolution in bits.
REQ-002 Parameter NCHAN, 4, number of analogue input channels (2..16).
REQ-003 Parameter TSAMPLE, 4, sampling phase length in clock cycles (>=1).
REQ-004 Parameter STEP_SIZE, 4, minimum clock cycles per bit decision (>=2).
REQ-005 Parameter TIMEOUT, 15, max cycles after ms_sar_clock rise to wait for ms_sar_rdy (>STEP_SIZE).
REQ-006 f100m_clk  in  1  system clock, rising edge.
REQ-007 rstb  in  1  asynchronous, active-low reset.
REQ-008 atpg  in  1  test mode; forces ms_sar_sample, ms_sar_sw, ms_sar_swb, ms_sar_sel to 0.
REQ-009 sar_soc  in  1  start-of-conversion toggle, synchronous to f100m_clk.
REQ-010 sar_chan_mask  in  NCHAN  channels to convert in the sequence.
REQ-011 sar_avg  in  2  log2 of conversions averaged per channel (1, 2, 4, 8).
REQ-012 sar_busy  out  1  sequence in progress.
REQ-013 sar_eoc  out  1  toggles once per channel result.
REQ-014 sar_err  out  1  toggles on ready timeout or empty mask.
REQ-015 sar_warn  out  1  toggles on contradictory comparator decision.
REQ-016 sar_code  out  NBIT  last channel result.
REQ-017 sar_chan  out  clog2(NCHAN)  channel index of sar_code.
REQ-018 ms_sar_dh, ms_sar_dl, ms_sar_rdy  in  1 each  comparator high, low, ready.
REQ-019 ms_sar_clock, ms_sar_sample  out  1 each  comparator strobe, sample switch.
REQ-020 ms_sar_sel  out  NCHAN  one-hot input mux select.
REQ-021 ms_sar_sw, ms_sar_swb  out  NBIT each  DAC trial code and its complement.

Function
REQ-022 A soc event is any sar_soc value differing from its registered copy; while sar_busy=1 it is ignored without side effect.
REQ-023 At an accepted soc, sar_chan_mask and sar_avg are captured; mask==0 toggles sar_err and remains IDLE.
REQ-024 FSM states: IDLE, SAMPLE, CONV, ACC, DONE; sar_busy=1 in every state except IDLE.
REQ-025 IDLE->SAMPLE on accepted soc with non-zero mask; channel = lowest set mask bit.
REQ-026 SAMPLE lasts TSAMPLE cycles: ms_sar_sample=1, ms_sar_sel one-hot of current channel, sw=swb=0.
REQ-027 CONV resolves bits MSB to LSB; each step's first cycle sets the trial bit in sw and asserts ms_sar_clock for exactly that cycle.
REQ-028 During CONV ms_sar_swb = ~ms_sar_sw; outside CONV both are 0.
REQ-029 A decision is taken at the first cycle >= step cycle STEP_SIZE-1 where ms_sar_rdy=1: dh=1 keeps the bit; dh=0 clears it.
REQ-030 dh=1 and dl=1 together keeps the bit and toggles sar_warn once per occurrence.
REQ-031 No ms_sar_rdy by step cycle TIMEOUT toggles sar_err, aborts the sequence, returns to IDLE with no eoc; sar_code is unchanged.
REQ-032 ACC (1 cycle) adds the NBIT code into an NBIT+3 bit accumulator, then repeats SAMPLE until 2^avg conversions are done, else goes to DONE.
REQ-033 DONE (1 cycle) registers sar_code = accumulator >> avg (truncating), sets sar_chan, toggles sar_eoc, and clears the accumulator.
REQ-034 From DONE, go to SAMPLE for the next higher set mask bit, else to IDLE.
REQ-035 Nominal per-conversion latency = TSAMPLE + NBIT*STEP_SIZE + 1 cycles; DONE adds 1 cycle per channel.

Reset
REQ-036 rstb low asynchronously forces IDLE and clears every output, the accumulator, counters and the soc copy to 0, including mid-conversion.
REQ-037 After rstb release, no soc event is detected until sar_soc differs from its value sampled at the first post-reset edge.

Verification (NBIT=10, NCHAN=4, TSAMPLE=4, STEP_SIZE=4, immediate rdy)
REQ-038 Reset held 5 cycles -> all outputs 0; release with sar_soc=0 -> sar_busy stays 0.
REQ-039 mask=0001, avg=0, model code 0x2AA -> sar_eoc toggles 46 cycles after soc; sar_code=0x2AA; sar_chan=0.
REQ-040 mask=1010, codes ch1=0x100, ch3=0x3FF -> two eoc toggles in order; chan 1 then 3; sar_busy falls after the second.
REQ-041 avg=2, successive codes 100,101,102,103 -> single eoc; sar_code=101.
REQ-042 ms_sar_rdy stuck 0 -> sar_err toggles 15 cycles after first ms_sar_clock; no eoc; sar_busy=0.
REQ-043 dh=dl=1 at MSB -> sar_warn toggles once, MSB kept; rstb pulse mid-CONV -> all outputs 0 and IDLE.
